// File: rtl/vape_pkg.sv
// Shared types and widths for the VAPE execution aggregator.
package vape_pkg;

    typedef enum logic [1:0] {
        KILL = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int VIOL_CNT_W  = 8;
    localparam int PULSE_CNT_W = 8;

endpackage

// File: rtl/vape_rst_pulse.sv
// Retriggerable reset-request pulse: high for RST_CYCLES cycles after the last trigger.
module vape_rst_pulse
    import vape_pkg::*;
#(
    parameter int RST_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic pulse
);

    localparam logic [PULSE_CNT_W-1:0] LOAD = PULSE_CNT_W'(RST_CYCLES);

    logic [PULSE_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (trigger) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/vape_exec_aggregator.sv
// Combines sub-monitor exec bits into the attestation EXEC flag via a KILL/RUN/DONE FSM.
// Optional reset-request pulse on violation is enabled by VAPE_RESET_ON_VIOLATION_EN.
module vape_exec_aggregator
    import vape_pkg::*;
#(
    parameter int N_MON      = 4,
    parameter int RST_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           pc,
    input  logic [15:0]           ER_min,
    input  logic [15:0]           ER_max,
    input  logic [N_MON-1:0]      mon_exec,
    output logic                  exec,
    output logic [1:0]            state_o,
    output logic [VIOL_CNT_W-1:0] viol_cnt,
    output logic [N_MON-1:0]      viol_src,
    output logic                  reset_req
);

    state_t state, next_state;
    logic   ok, er_ok, in_er;
    logic   viol, enter_run;

    assign ok    = &mon_exec;
    assign er_ok = (ER_min <= ER_max);
    assign in_er = (pc >= ER_min) && (pc <= ER_max);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        viol       = 1'b0;
        enter_run  = 1'b0;
        case (state)
            KILL: begin
                if (er_ok && ok && (pc == ER_min)) begin
                    next_state = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                if (!er_ok)               next_state = KILL;
                else if (!ok)             viol       = 1'b1;
                else if (pc == ER_max)    next_state = DONE;
                else if (!in_er)          viol       = 1'b1;
            end
            DONE: begin
                if (!er_ok)                         next_state = KILL;
                else if (!ok)                       viol       = 1'b1;
                else if (in_er && (pc != ER_min))   viol       = 1'b1;
                else if (pc == ER_min)              next_state = RUN;
            end
            default: next_state = KILL;
        endcase
        // A violation overrides whatever transition was selected above.
        if (viol) next_state = KILL;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= KILL;
            exec     <= 1'b0;
            viol_cnt <= '0;
            viol_src <= '0;
        end else begin
            state <= next_state;
            exec  <= (state != KILL);
            if (viol && (viol_cnt != '1)) viol_cnt <= viol_cnt + 1'b1;
            if (enter_run)                viol_src <= '0;
            else if (viol)                viol_src <= viol_src | ~mon_exec;
        end
    end

    assign state_o = state;

`ifdef VAPE_RESET_ON_VIOLATION_EN
    vape_rst_pulse #(
        .RST_CYCLES(RST_CYCLES)
    ) u_rst_pulse (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (viol),
        .pulse   (reset_req)
    );
`else
    assign reset_req = 1'b0;
`endif

endmodule

// File: tb/tb_vape_exec_aggregator.sv
// Scoreboard bench for vape_exec_aggregator: directed vectors push expectations, a monitor compares.
module tb_vape_exec_aggregator;

`ifdef VAPE_RESET_ON_VIOLATION_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    localparam logic [1:0] S_KILL = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [15:0] ER_min = 16'hE000;
    logic [15:0] ER_max = 16'hE0FE;
    logic [3:0]  mon_exec = 4'hF;
    logic        exec;
    logic [1:0]  state_o;
    logic [7:0]  viol_cnt;
    logic [3:0]  viol_src;
    logic        reset_req;

    vape_exec_aggregator #(.N_MON(4), .RST_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .ER_min    (ER_min),
        .ER_max    (ER_max),
        .mon_exec  (mon_exec),
        .exec      (exec),
        .state_o   (state_o),
        .viol_cnt  (viol_cnt),
        .viol_src  (viol_src),
        .reset_req (reset_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       ex;
        logic [7:0] cnt;
        logic [3:0] src;
        logic       rr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            check("state_o",   32'(state_o),   32'(e.st));
            check("exec",      32'(exec),      32'(e.ex));
            check("viol_cnt",  32'(viol_cnt),  32'(e.cnt));
            check("viol_src",  32'(viol_src),  32'(e.src));
            check("reset_req", 32'(reset_req), 32'(e.rr));
        end
    end

    task automatic step(input logic [15:0] p, input logic [3:0] m, input logic [1:0] st,
                        input logic ex, input logic [7:0] cnt, input logic [3:0] src, input logic rr);
        exp_t x;
        @(posedge clk);
        #1;
        pc       = p;
        mon_exec = m;
        x = '{cyc + 1, st, ex, cnt, src, rr};
        q.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("queue_drain", 32'(q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},     32'(state_o),   32'd0);
        check({tag, "_exec"},      32'(exec),      32'd0);
        check({tag, "_viol_cnt"},  32'(viol_cnt),  32'd0);
        check({tag, "_viol_src"},  32'(viol_src),  32'd0);
        check({tag, "_reset_req"}, 32'(reset_req), 32'd0);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ecnt;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        rst_n = 1'b1;

        // Normal entry, traversal to ER_max, idle in DONE, re-entry.
        step(16'h0000, 4'hF, S_KILL, 0, 8'd0, 4'h0, 0);
        step(16'hE000, 4'hF, S_RUN,  0, 8'd0, 4'h0, 0);
        step(16'hE002, 4'hF, S_RUN,  1, 8'd0, 4'h0, 0);
        step(16'hE0FE, 4'hF, S_DONE, 1, 8'd0, 4'h0, 0);
        step(16'h4000, 4'hF, S_DONE, 1, 8'd0, 4'h0, 0);
        step(16'hE000, 4'hF, S_RUN,  1, 8'd0, 4'h0, 0);
        step(16'hE002, 4'hF, S_RUN,  1, 8'd0, 4'h0, 0);

        // ivt_protect drops for one cycle in RUN; pulse lasts four cycles.
        step(16'hE004, 4'hE, S_KILL, 1, 8'd1, 4'h1, RR);
        step(16'hE006, 4'hF, S_KILL, 0, 8'd1, 4'h1, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd1, 4'h1, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd1, 4'h1, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd1, 4'h1, 0);

        // Re-entry clears viol_src; mid-region entry from DONE is a violation.
        step(16'hE000, 4'hF, S_RUN,  0, 8'd1, 4'h0, 0);
        step(16'hE0FE, 4'hF, S_DONE, 1, 8'd1, 4'h0, 0);
        step(16'hE010, 4'hF, S_KILL, 1, 8'd2, 4'h0, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd2, 4'h0, RR);
        step(16'hE000, 4'hF, S_RUN,  0, 8'd2, 4'h0, RR);
        step(16'hE002, 4'hF, S_RUN,  1, 8'd2, 4'h0, RR);
        step(16'hE0FE, 4'hF, S_DONE, 1, 8'd2, 4'h0, 0);

        // ER_min together with mon_exec[2]=0: violation in DONE, ignored in KILL.
        step(16'hE000, 4'hB, S_KILL, 1, 8'd3, 4'h4, RR);
        step(16'hE000, 4'hB, S_KILL, 0, 8'd3, 4'h4, RR);
        step(16'hE000, 4'hB, S_KILL, 0, 8'd3, 4'h4, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd3, 4'h4, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd3, 4'h4, 0);

        // Leaving the ER from RUN, then a second violation two cycles into the pulse.
        step(16'hE000, 4'hF, S_RUN,  0, 8'd3, 4'h0, 0);
        step(16'h1234, 4'hF, S_KILL, 1, 8'd4, 4'h0, RR);
        step(16'hE000, 4'hF, S_RUN,  0, 8'd4, 4'h0, RR);
        step(16'hE002, 4'hD, S_KILL, 1, 8'd5, 4'h2, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd5, 4'h2, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd5, 4'h2, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd5, 4'h2, RR);
        step(16'h0000, 4'hF, S_KILL, 0, 8'd5, 4'h2, 0);

        // Inverted ER: never leaves KILL.
        ER_min = 16'hE100;
        ER_max = 16'hE000;
        step(16'hE100, 4'hF, S_KILL, 0, 8'd5, 4'h2, 0);
        step(16'hE000, 4'hF, S_KILL, 0, 8'd5, 4'h2, 0);
        step(16'hE100, 4'hB, S_KILL, 0, 8'd5, 4'h2, 0);
        ER_min = 16'hE000;
        ER_max = 16'hE0FE;

        // 300 violations saturate the counter.
        ecnt = 8'd5;
        for (int i = 0; i < 300; i++) begin
            step(16'hE000, 4'hF, S_RUN, 0, ecnt, 4'h0, (i == 0) ? 1'b0 : RR);
            if (ecnt != 8'hFF) ecnt = ecnt + 8'd1;
            step(16'hE002, 4'hE, S_KILL, 1, ecnt, 4'h1, RR);
        end
        step(16'h0000, 4'hF, S_KILL, 0, 8'hFF, 4'h1, RR);

        // Enter RUN with a pulse active, then assert reset mid-cycle.
        step(16'hE000, 4'hF, S_RUN,  0, 8'hFF, 4'h0, RR);
        step(16'hE002, 4'hF, S_RUN,  1, 8'hFF, 4'h0, RR);
        step(16'hE004, 4'hE, S_KILL, 1, 8'hFF, 4'h1, RR);
        step(16'hE000, 4'hF, S_RUN,  0, 8'hFF, 4'h0, RR);
        step(16'hE002, 4'hF, S_RUN,  1, 8'hFF, 4'h0, RR);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // A fresh ER_min entry is required after reset.
        step(16'hE002, 4'hF, S_KILL, 0, 8'd0, 4'h0, 0);
        step(16'hE000, 4'hF, S_RUN,  0, 8'd0, 4'h0, 0);
        step(16'hE002, 4'hF, S_RUN,  1, 8'd0, 4'h0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
